// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline-register control
// outputs that pass between the 5-stage datapath and hazard_ctrl.
//
// Modports:
//   master - datapath side: drives the ID/EX/MEM hazard inputs and consumes
//            the PC / pipeline-register enables, holds and flushes.
//   slave  - controller side (hazard_ctrl).
//
// Signals:
//   id_rs, id_rt, id_uses_rt   source fields of the instruction in ID
//   ex_mem_read, ex_rt         load flag and destination of the instruction in EX
//   branch_taken               taken branch resolved in MEM
//   mem_busy                   data memory not ready
//   pc_write, if_id_write      PC / IF-ID load enables
//   id_ex_bubble, id_ex_hold   ID/EX control-zero and hold
//   ex_mem_hold                EX/MEM hold
//   if_id_flush, id_ex_flush   clears on a taken branch
//   timeout_err                sticky memory-timeout flag
//   state                      00 RUN, 01 LDSTALL
//
// Optional macro HAZARD_PERF_CNT_EN adds stall_cycles / flush_events.
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       branch_taken;
    logic       mem_busy;

    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_bubble;
    logic       id_ex_hold;
    logic       ex_mem_hold;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       timeout_err;
    logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
        input  pc_write, if_id_write, id_ex_bubble, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
        , input stall_cycles, flush_events
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
        output pc_write, if_id_write, id_ex_bubble, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, timeout_err, state
`ifdef HAZARD_PERF_CNT_EN
        , output stall_cycles, flush_events
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and stall controller for the 5-stage pipeline. Sequences the PC and
// the IF/ID, ID/EX, EX/MEM registers:
//   - freezes everything while data memory is busy (with a timeout watchdog),
//   - flushes IF/ID and ID/EX on a taken branch,
//   - inserts LOAD_STALL_CYC bubbles into ID/EX on a load-use hazard.
// Priority: mem_busy > branch_taken > new load-use (RUN) > LDSTALL > run.
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   hz     hazard_ctrl_if.slave (hazard inputs, pipeline control outputs)
//
// Parameters:
//   LOAD_STALL_CYC  bubbles per load-use hazard (1..15)
//   BUSY_W          width of the busy-cycle counter
//   MEM_TIMEOUT     consecutive busy cycles that set timeout_err
//
// Optional macro HAZARD_PERF_CNT_EN: adds saturating stall_cycles and
// flush_events counters on the interface.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int LOAD_STALL_CYC = 1,
    parameter int BUSY_W         = 8,
    parameter int MEM_TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hz
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [3:0]        stall_cnt_q, stall_cnt_d;
    logic [BUSY_W-1:0] busy_cnt_q;
    logic              timeout_q;
    logic              load_use;

    logic pc_write, if_id_write, id_ex_bubble, id_ex_hold, ex_mem_hold;
    logic if_id_flush, id_ex_flush, timeout_err;
    logic [1:0] state;

    // Busy counter parks at MEM_TIMEOUT so a stuck memory cannot wrap it.
    function automatic logic [BUSY_W-1:0] busy_sat_inc(input logic [BUSY_W-1:0] v);
        if (v >= BUSY_W'(MEM_TIMEOUT))
            return BUSY_W'(MEM_TIMEOUT);
        return v + 1'b1;
    endfunction

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // ---- state register -----------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= RUN;
            stall_cnt_q <= 4'd0;
        end else begin
            fsm_q       <= fsm_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ---- memory-busy watchdog -----------------------------------------------
    // timeout_err sets on the edge where busy_cnt reaches MEM_TIMEOUT and then
    // stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else if (hz.mem_busy) begin
            busy_cnt_q <= busy_sat_inc(busy_cnt_q);
            if (busy_cnt_q >= BUSY_W'(MEM_TIMEOUT - 1))
                timeout_q <= 1'b1;
        end else begin
            busy_cnt_q <= '0;
        end
    end

    // ---- next-state logic ---------------------------------------------------
    // A busy memory freezes the stall sequence: busy cycles do not consume
    // stall_cnt, and a branch waiting behind them is acted on afterwards.
    always_comb begin
        fsm_d       = fsm_q;
        stall_cnt_d = stall_cnt_q;
        if (!hz.mem_busy) begin
            if (hz.branch_taken) begin
                fsm_d       = RUN;
                stall_cnt_d = 4'd0;
            end else if (fsm_q == RUN && load_use) begin
                if (LOAD_STALL_CYC > 1) begin
                    fsm_d       = LDSTALL;
                    stall_cnt_d = 4'(LOAD_STALL_CYC - 1);
                end
            end else if (fsm_q == LDSTALL) begin
                stall_cnt_d = stall_cnt_q - 4'd1;
                if (stall_cnt_q == 4'd1)
                    fsm_d = RUN;
            end
        end
    end

    // ---- output logic -------------------------------------------------------
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        timeout_err  = timeout_q;
        state        = fsm_q;

        if (!rst_n) begin
            // Pipeline free-runs while reset is held; no stale bubble survives.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            timeout_err = 1'b0;
            state       = RUN;
        end else if (hz.mem_busy) begin
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
        end else if (hz.branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end else if ((fsm_q == RUN && load_use) || fsm_q == LDSTALL) begin
            id_ex_bubble = 1'b1;
        end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.if_id_write  = if_id_write;
    assign hz.id_ex_bubble = id_ex_bubble;
    assign hz.id_ex_hold   = id_ex_hold;
    assign hz.ex_mem_hold  = ex_mem_hold;
    assign hz.if_id_flush  = if_id_flush;
    assign hz.id_ex_flush  = id_ex_flush;
    assign hz.timeout_err  = timeout_err;
    assign hz.state        = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] flush_events_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- performance counters -----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 16'd0;
            flush_events_q <= 16'd0;
        end else begin
            if (!pc_write)
                stall_cycles_q <= sat_inc16(stall_cycles_q);
            if (if_id_flush)
                flush_events_q <= sat_inc16(flush_events_q);
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (LOAD_STALL_CYC=1/MEM_TIMEOUT=255
// and LOAD_STALL_CYC=3/MEM_TIMEOUT=4) share one stimulus stream. A behavioural
// model tracks "bubbles still owed", consecutive busy cycles and the sticky
// timeout per instance; a compare process checks every negedge. Directed
// sequences with literal expectations pin the model.
module tb_hazard_ctrl;
    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, branch_taken, mem_busy;

    int checks = 0;
    int errors = 0;

    hazard_ctrl_if if_a ();
    hazard_ctrl_if if_b ();

    assign if_a.id_rs = id_rs;           assign if_b.id_rs = id_rs;
    assign if_a.id_rt = id_rt;           assign if_b.id_rt = id_rt;
    assign if_a.id_uses_rt = id_uses_rt; assign if_b.id_uses_rt = id_uses_rt;
    assign if_a.ex_mem_read = ex_mem_read; assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.ex_rt = ex_rt;           assign if_b.ex_rt = ex_rt;
    assign if_a.branch_taken = branch_taken; assign if_b.branch_taken = branch_taken;
    assign if_a.mem_busy = mem_busy;     assign if_b.mem_busy = mem_busy;

    hazard_ctrl #(.LOAD_STALL_CYC(1), .BUSY_W(8), .MEM_TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .hz(if_a));
    hazard_ctrl #(.LOAD_STALL_CYC(3), .BUSY_W(8), .MEM_TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .hz(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: pc_write, if_id_write, bubble, id_ex_hold,
    // ex_mem_hold, if_id_flush, id_ex_flush, timeout_err, state[1:0]
    logic [9:0] got_a, got_b;
    assign got_a = {if_a.pc_write, if_a.if_id_write, if_a.id_ex_bubble, if_a.id_ex_hold,
                    if_a.ex_mem_hold, if_a.if_id_flush, if_a.id_ex_flush,
                    if_a.timeout_err, if_a.state};
    assign got_b = {if_b.pc_write, if_b.if_id_write, if_b.id_ex_bubble, if_b.id_ex_hold,
                    if_b.ex_mem_hold, if_b.if_id_flush, if_b.id_ex_flush,
                    if_b.timeout_err, if_b.state};

    // ---------------- behavioural model ----------------
    int lsc [2] = '{1, 3};
    int tmo [2] = '{255, 4};
    int pend[2] = '{0, 0};   // bubbles still owed after the current one
    int bcnt[2] = '{0, 0};   // consecutive busy cycles seen
    bit err [2] = '{0, 0};

    function automatic bit hazard();
        return ex_mem_read && ex_rt != 0 &&
               (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
    endfunction

    function automatic logic [9:0] model_out(int k);
        logic pw, iw, bb, h1, h2, f1, f2, te;
        logic [1:0] st;
        pw = 0; iw = 0; bb = 0; h1 = 0; h2 = 0; f1 = 0; f2 = 0;
        te = err[k];
        st = (pend[k] > 0) ? 2'b01 : 2'b00;
        if (!rst_n) begin
            pw = 1; iw = 1; te = 0; st = 2'b00;
        end else if (mem_busy) begin
            h1 = 1; h2 = 1;
        end else if (branch_taken) begin
            f1 = 1; f2 = 1; pw = 1; iw = 1;
        end else if (pend[k] > 0 || hazard()) begin
            bb = 1;
        end else begin
            pw = 1; iw = 1;
        end
        return {pw, iw, bb, h1, h2, f1, f2, te, st};
    endfunction

    always @(negedge clk) begin
        logic [9:0] exp_v, got_v;
        for (int k = 0; k < 2; k++) begin
            exp_v = model_out(k);
            got_v = (k == 0) ? got_a : got_b;
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model_cmp dut%0d t=%0t got %b expected %b", k, $time, got_v, exp_v);
            end
        end
        // advance the model to what the next rising edge will produce
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                pend[k] = 0; bcnt[k] = 0; err[k] = 0;
            end else if (mem_busy) begin
                bcnt[k] = (bcnt[k] + 1 > tmo[k]) ? tmo[k] : bcnt[k] + 1;
                if (bcnt[k] == tmo[k]) err[k] = 1;
            end else begin
                bcnt[k] = 0;
                if (branch_taken)       pend[k] = 0;
                else if (pend[k] > 0)   pend[k] = pend[k] - 1;
                else if (hazard())      pend[k] = lsc[k] - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string nm, logic [3:0] got, logic [3:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, expv);
        end
    endtask

    task automatic set_in(logic mr, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                          logic uses, logic br, logic busy);
        ex_mem_read = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        id_uses_rt = uses; branch_taken = br; mem_busy = busy;
    endtask

    task automatic next_cyc(); @(posedge clk); #1; endtask
    task automatic at_chk();   @(negedge clk); #1; endtask

    task automatic do_reset();
        next_cyc();
        rst_n = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        next_cyc();
        rst_n = 1;
    endtask

    int burst;

    initial begin
        rst_n = 0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        next_cyc();
        chk("rst_pc_write", if_a.pc_write, 1);
        chk("rst_if_id_write", if_b.if_id_write, 1);
        chk("rst_bubble", if_b.id_ex_bubble, 0);
        chk("rst_state", if_b.state, 0);
        chk("rst_timeout", if_b.timeout_err, 0);
        next_cyc();
        rst_n = 1;

        // load-use on rs, then release (A: 1 bubble, B: 3 bubbles)
        set_in(1, 5, 5, 0, 0, 0, 0); at_chk();
        chk("lu_a_pc", if_a.pc_write, 0);
        chk("lu_a_ifid", if_a.if_id_write, 0);
        chk("lu_a_bub", if_a.id_ex_bubble, 1);
        chk("lu_a_state", if_a.state, 0);
        chk("lu_b_bub1", if_b.id_ex_bubble, 1);
        next_cyc(); set_in(0, 5, 5, 0, 0, 0, 0); at_chk();
        chk("lu_a_pc_after", if_a.pc_write, 1);
        chk("lu_a_bub_after", if_a.id_ex_bubble, 0);
        chk("lu_b_bub2", if_b.id_ex_bubble, 1);
        chk("lu_b_state2", if_b.state, 1);
        next_cyc(); at_chk();
        chk("lu_b_bub3", if_b.id_ex_bubble, 1);
        chk("lu_b_state3", if_b.state, 1);
        next_cyc(); at_chk();
        chk("lu_b_bub4", if_b.id_ex_bubble, 0);
        chk("lu_b_pc4", if_b.pc_write, 1);
        chk("lu_b_state4", if_b.state, 0);

        // non-hazards and rt hazard
        next_cyc(); set_in(1, 0, 0, 0, 0, 0, 0); at_chk();
        chk("nh_r0_pc", if_a.pc_write, 1);
        next_cyc(); set_in(1, 7, 1, 7, 0, 0, 0); at_chk();
        chk("nh_rt_unused_pc", if_a.pc_write, 1);
        next_cyc(); set_in(1, 7, 1, 7, 1, 0, 0); at_chk();
        chk("rt_used_pc", if_a.pc_write, 0);
        chk("rt_used_bub", if_a.id_ex_bubble, 1);
        do_reset();

        // branch on 2nd stall cycle
        set_in(1, 5, 5, 0, 0, 0, 0); at_chk();
        next_cyc(); set_in(0, 0, 0, 0, 0, 1, 0); at_chk();
        chk("br_flush_ifid", if_b.if_id_flush, 1);
        chk("br_flush_idex", if_b.id_ex_flush, 1);
        chk("br_pc", if_b.pc_write, 1);
        chk("br_bub", if_b.id_ex_bubble, 0);
        next_cyc(); set_in(0, 0, 0, 0, 0, 0, 0); at_chk();
        chk("br_after_state", if_b.state, 0);
        chk("br_after_bub", if_b.id_ex_bubble, 0);
        do_reset();

        // busy with branch pending during a stall
        set_in(1, 5, 5, 0, 0, 0, 0); at_chk();
        for (int i = 0; i < 4; i++) begin
            next_cyc(); set_in(0, 0, 0, 0, 0, 1, 1); at_chk();
            chk("bz_hold_idex", if_b.id_ex_hold, 1);
            chk("bz_hold_exmem", if_b.ex_mem_hold, 1);
            chk("bz_flush", if_b.if_id_flush, 0);
            chk("bz_state", if_b.state, 1);
        end
        next_cyc(); set_in(0, 0, 0, 0, 0, 1, 0); at_chk();
        chk("bz_release_flush", if_b.id_ex_flush, 1);
        next_cyc(); set_in(0, 0, 0, 0, 0, 0, 0); at_chk();
        chk("bz_release_state", if_b.state, 0);
        do_reset();

        // timeout watchdog (MEM_TIMEOUT=4 on B)
        set_in(0, 0, 0, 0, 0, 0, 1);
        next_cyc(); next_cyc();
        next_cyc(); set_in(0, 0, 0, 0, 0, 0, 0); at_chk();
        chk("to_3busy", if_b.timeout_err, 0);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); set_in(0, 0, 0, 0, 0, 0, 1);
        end
        at_chk();
        chk("to_before_4th_edge", if_b.timeout_err, 0);
        next_cyc(); set_in(0, 0, 0, 0, 0, 0, 0); at_chk();
        chk("to_set", if_b.timeout_err, 1);
        next_cyc(); set_in(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk); #2;
        rst_n = 0; #1;
        chk("async_rst_timeout", if_b.timeout_err, 0);
        chk("async_rst_pc", if_b.pc_write, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #2;
        rst_n = 1;

        // randomized phase
        burst = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cyc();
            rst_n = ($urandom_range(0, 199) != 0);
            if (c == 1500) burst = 260;
            if (burst > 0) begin
                mem_busy = 1; burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                mem_busy = 1; burst = $urandom_range(0, 5);
            end else begin
                mem_busy = 0;
            end
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            ex_rt        = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_uses_rt   = ($urandom_range(0, 1) == 1);
            branch_taken = ($urandom_range(0, 7) == 0);
        end
        next_cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage datapath.
- Sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC.
- Detects load-use hazards and inserts bubbles into ID/EX, flushes younger stages on a taken branch, and freezes the whole pipeline while data memory is busy, with a timeout watchdog.

Parameters:
LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (legal 1..15)
BUSY_W, 8, width of the memory-busy cycle counter
MEM_TIMEOUT, 255, consecutive busy cycles that set timeout_err (1..2^BUSY_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  mem_read control held in the ID/EX register (instruction in EX)
ex_rt  in  5  destination register of the instruction in EX (reg2 of the ID/EX register)
branch_taken  in  1  taken branch resolved in MEM
mem_busy  in  1  data memory not ready
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
id_ex_bubble  out  1  zero all control fields entering ID/EX
id_ex_hold  out  1  ID/EX holds its value
ex_mem_hold  out  1  EX/MEM holds its value
if_id_flush  out  1  clear IF/ID
id_ex_flush  out  1  clear ID/EX
timeout_err  out  1  sticky memory-timeout flag
state  out  2  00 RUN, 01 LDSTALL

Behaviour:
- Registered state: fsm (RUN/LDSTALL), stall_cnt[3:0], busy_cnt[BUSY_W-1:0], timeout_err. All reset asynchronously to RUN/0/0/0.
- Control outputs are combinational from the registered state and current inputs.
- While rst_n=0, outputs are forced to: pc_write=1, if_id_write=1, all others 0.
- load_use = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Evaluation is in strict priority order, first match wins:
  1. mem_busy=1 (freeze):
     - Outputs: pc_write=0, if_id_write=0, id_ex_hold=1, ex_mem_hold=1; bubble and both flushes 0.
     - fsm and stall_cnt hold.
     - busy_cnt increments, saturating at MEM_TIMEOUT.
     - timeout_err sets on the edge where busy_cnt reaches MEM_TIMEOUT, i.e. after MEM_TIMEOUT consecutive busy cycles.
  2. branch_taken=1:
     - Outputs: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1; holds and bubble 0.
     - Next: fsm=RUN, stall_cnt=0. A pending load stall is abandoned.
  3. fsm=RUN and load_use:
     - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
     - If LOAD_STALL_CYC>1: next fsm=LDSTALL, stall_cnt=LOAD_STALL_CYC-1. Otherwise fsm stays RUN.
  4. fsm=LDSTALL:
     - Outputs: pc_write=0, if_id_write=0, id_ex_bubble=1.
     - stall_cnt decrements; when stall_cnt==1, next fsm=RUN.
     - load_use is ignored in this state.
  5. Otherwise: pc_write=1, if_id_write=1, all other control outputs 0.
- busy_cnt clears on any cycle with mem_busy=0.
- timeout_err clears only on reset.
- Total load-use penalty is exactly LOAD_STALL_CYC non-busy cycles. Busy cycles extend it without consuming stall_cnt.
- A branch_taken arriving during mem_busy is not acted on; it takes effect on the first non-busy cycle. EX/MEM is held, so the input stays asserted.
- Reset mid-stall returns to RUN immediately; no bubble persists after rst_n rises.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles[15:0] and flush_events[15:0]. Both are saturating counters with async reset to 0.
  - stall_cycles increments on every cycle with pc_write=0 and rst_n=1.
  - flush_events increments on every cycle where if_id_flush=1.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Load-use on rs, default params: ex_mem_read=1, ex_rt=5, id_rs=5 -> same cycle pc_write=0, if_id_write=0, id_ex_bubble=1, state=00. Next cycle with ex_mem_read=0 -> pc_write=1, bubble=0.
2. Non-hazards:
   - ex_rt=0, id_rs=0, ex_mem_read=1 -> pc_write=1.
   - ex_rt=7=id_rt with id_uses_rt=0 -> no stall.
   - Same with id_uses_rt=1 -> stall.
3. LOAD_STALL_CYC=3, load_use pulse of one cycle -> bubble high exactly 3 cycles; state=01 on cycles 2-3; back to 00 on cycle 4 with pc_write=1.
4. LOAD_STALL_CYC=3, branch_taken on the 2nd stall cycle -> that cycle both flushes=1, pc_write=1, bubble=0; next cycle state=00 with no further bubble.
5. LOAD_STALL_CYC=3, mem_busy high for 4 cycles starting at the 2nd stall cycle, with branch_taken=1 throughout:
   - Busy cycles: all holds=1, flushes=0, state frozen at 01.
   - First non-busy cycle: flushes=1.
   - Next cycle: state=00.
6. MEM_TIMEOUT=4:
   - mem_busy high 3 cycles -> timeout_err=0.
   - Then low 1 cycle, then high 4 cycles -> timeout_err=1 after the 4th busy edge, still 1 after mem_busy drops.
   - rst_n pulsed low mid-cycle -> timeout_err=0 and pc_write=1 immediately, asynchronously.
